// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the loader FSM state encoding, error codes and the memory word width.
// Imported by the top-level loader and its byte-to-word packer.
package imem_loader_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs 4 little-endian bytes into a 32-bit word.
// Latency: 4th byte accepted in cycle t -> word_vld/word_dat in cycle t+1.
// Backpressure: none; accepts a byte whenever in_vld is high; clr drops a partial word.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [7:0]        in_dat,
  output logic              last_byte,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_dat
);

  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       shf_q, shf_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              vld_q, vld_d;

  // Shift bytes in from the top so byte 0 lands in bits [7:0] of the finished word.
  always_comb begin
    cnt_d     = cnt_q;
    shf_d     = shf_q;
    word_d    = word_q;
    vld_d     = 1'b0;
    last_byte = in_vld && (cnt_q == 2'd3);
    if (clr) begin
      cnt_d = 2'd0;
      shf_d = 24'd0;
    end else if (in_vld) begin
      if (cnt_q == 2'd3) begin
        word_d = {in_dat, shf_q};
        vld_d  = 1'b1;
        cnt_d  = 2'd0;
        shf_d  = 24'd0;
      end else begin
        shf_d = {in_dat, shf_q[23:8]};
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // Packer state register; the output word holds between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      shf_q  <= 24'd0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      shf_q  <= shf_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word_vld = vld_q;
  assign word_dat = word_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader (count, data, xor checksum) writing instruction memory; holds core reset until clean load.
// Latency: last byte of a word -> mem_we next cycle; good checksum at t -> load_done t+1, cpu_rst low t+2.
// Backpressure: byte_ready low only in reset and after a completed load; ERR drains bytes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic [1:0]        err_code
);

  localparam logic [15:0]     DEPTH_L = 16'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              load_done_q, load_done_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [1:0]        err_q, err_d;

  logic              xfer;
  logic              pk_vld, pk_last;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   idx_nxt;

  assign byte_ready = !rst && (state_q != DONE);
  assign xfer       = byte_valid && byte_ready;
  assign pk_vld     = xfer && (state_q == DATA);
  assign len_full   = {byte_data, len_lo_q};
  assign idx_nxt    = word_idx_q + IDX_ONE;

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q != DATA),
    .in_vld    (pk_vld),
    .in_dat    (byte_data),
    .last_byte (pk_last),
    .word_vld  (mem_we),
    .word_dat  (mem_wdata)
  );

  // Frame FSM: length bytes, data words, checksum, then terminal DONE or ERR.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    csum_d      = csum_q;
    waddr_d     = waddr_q;
    load_done_d = load_done_q;
    cpu_rst_d   = cpu_rst_q;
    err_d       = err_q;
    case (state_q)
      LEN0: if (xfer) begin
        len_lo_d = byte_data;
        state_d  = LEN1;
      end
      LEN1: if (xfer) begin
        count_d = len_full[ADDR_W:0];
        if (len_full > DEPTH_L) begin
          state_d = ERR;
          err_d   = ERR_LEN;
        end else if (len_full == 16'd0) begin
          state_d = CSUM;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (xfer) begin
        csum_d = csum_q ^ byte_data;
        // Address is captured here so it appears alongside the packer's strobe next cycle.
        if (pk_last) begin
          waddr_d    = word_idx_q[ADDR_W-1:0];
          word_idx_d = idx_nxt;
          if (idx_nxt == count_q) state_d = CSUM;
        end
      end
      CSUM: if (xfer) begin
        if (byte_data == csum_q) begin
          state_d     = DONE;
          load_done_d = 1'b1;
        end else begin
          state_d = ERR;
          err_d   = ERR_CSUM;
        end
      end
      DONE: cpu_rst_d = 1'b0;
      ERR:  ;
      default: state_d = LEN0;
    endcase
  end

  // Loader state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LEN0;
      len_lo_q    <= 8'd0;
      count_q     <= '0;
      word_idx_q  <= '0;
      csum_q      <= 8'd0;
      waddr_q     <= '0;
      load_done_q <= 1'b0;
      cpu_rst_q   <= 1'b1;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      csum_q      <= csum_d;
      waddr_q     <= waddr_d;
      load_done_q <= load_done_d;
      cpu_rst_q   <= cpu_rst_d;
      err_q       <= err_d;
    end
  end

  assign mem_waddr = waddr_q;
  assign cpu_rst   = cpu_rst_q;
  assign load_done = load_done_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good frames, gapped frames, length and checksum errors, empty frame, mid-frame reset.
// Inputs change #1 after posedge; outputs are sampled on negedge.
// Memory writes are logged by a negedge monitor and compared against hand-computed words.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  frm[$];
  logic [4:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(.ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_waddr);
      wr_data.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wr_addr.delete(); wr_data.delete();
  endtask

  // Streams frm; optional random idle gaps between bytes. Returns #1 after the last acceptance edge.
  task automatic send(input bit gaps);
    int w;
    for (int i = 0; i < frm.size(); i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      byte_valid = 1'b1;
      byte_data  = frm[i];
      w = 0;
      @(negedge clk);
      while (!byte_ready && w < 20) begin
        w++;
        @(negedge clk);
      end
      if (w >= 20) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: byte %0d (0x%02h) never accepted", i, frm[i]);
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", byte_ready); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_waddr !== 5'd0) begin n_bad++; $display("FAIL rst_waddr: got %0d want 0", mem_waddr); end
    n_cmp++; if (mem_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_rst_after: got %b want 1", cpu_rst); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", load_done); end
    n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL rst_err: got %0d want 0", err_code); end
    n_cmp++; if (byte_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", byte_ready); end
  endtask

  // Two-word good frame; checks strobes, done latency and cpu_rst release one cycle later.
  task automatic test_good_frame(input bit gaps, input string tag);
    do_reset();
    frm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    send(gaps);
    @(negedge clk);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %b want 1", tag, load_done); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL %s_cpu_rst_t1: got %b want 1", tag, cpu_rst); end
    @(negedge clk);
    n_cmp++; if (cpu_rst !== 1'b0) begin n_bad++; $display("FAIL %s_cpu_rst_t2: got %b want 0", tag, cpu_rst); end
    n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL %s_err: got %0d want 0", tag, err_code); end
    n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL %s_ready: got %b want 0", tag, byte_ready); end
    n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL %s_nwrites: got %0d want 2", tag, wr_addr.size()); end
    if (wr_addr.size() >= 2) begin
      n_cmp++; if (wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h00000013) begin n_bad++; $display("FAIL %s_w0: got %0d:%h want 0:00000013", tag, wr_addr[0], wr_data[0]); end
      n_cmp++; if (wr_addr[1] !== 5'd1 || wr_data[1] !== 32'h0000006F) begin n_bad++; $display("FAIL %s_w1: got %0d:%h want 1:0000006f", tag, wr_addr[1], wr_data[1]); end
    end
  endtask

  task automatic test_len_overflow();
    do_reset();
    frm = '{8'h21, 8'h00};
    send(1'b0);
    @(negedge clk);
    n_cmp++; if (err_code !== 2'd1) begin n_bad++; $display("FAIL len_err: got %0d want 1", err_code); end
    n_cmp++; if (byte_ready !== 1'b1) begin n_bad++; $display("FAIL len_ready: got %b want 1", byte_ready); end
    frm = '{8'hAA, 8'h55, 8'h13, 8'h00, 8'h00};
    send(1'b0);
    repeat (2) @(negedge clk);
    n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL len_nwrites: got %0d want 0", wr_addr.size()); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL len_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL len_done: got %b want 0", load_done); end
    n_cmp++; if (err_code !== 2'd1) begin n_bad++; $display("FAIL len_err_hold: got %0d want 1", err_code); end
  endtask

  task automatic test_csum_error();
    do_reset();
    frm = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send(1'b0);
    repeat (2) @(negedge clk);
    n_cmp++; if (err_code !== 2'd2) begin n_bad++; $display("FAIL csum_err: got %0d want 2", err_code); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL csum_done: got %b want 0", load_done); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL csum_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (wr_addr.size() != 1) begin n_bad++; $display("FAIL csum_nwrites: got %0d want 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      n_cmp++; if (wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h04030201) begin n_bad++; $display("FAIL csum_w0: got %0d:%h want 0:04030201", wr_addr[0], wr_data[0]); end
    end
  endtask

  task automatic test_empty_frame();
    do_reset();
    frm = '{8'h00, 8'h00, 8'h00};
    send(1'b0);
    @(negedge clk);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL empty_done: got %b want 1", load_done); end
    n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL empty_ready: got %b want 0", byte_ready); end
    byte_valid = 1'b1; byte_data = 8'h5A;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL empty_ready_hold: got %b want 0", byte_ready); end
    n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL empty_nwrites: got %0d want 0", wr_addr.size()); end
    n_cmp++; if (cpu_rst !== 1'b0) begin n_bad++; $display("FAIL empty_cpu_rst: got %b want 0", cpu_rst); end
    n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL empty_err: got %0d want 0", err_code); end
  endtask

  // Reset right after the 6th byte of a 2-word frame, then load a clean 1-word frame.
  task automatic test_reset_midframe();
    do_reset();
    frm = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send(1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL mid_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got %b want 0", byte_ready); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (wr_addr.size() != 1) begin n_bad++; $display("FAIL mid_nwrites: got %0d want 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      n_cmp++; if (wr_addr[0] !== 5'd0 || wr_data[0] !== 32'hDDCCBBAA) begin n_bad++; $display("FAIL mid_w0: got %0d:%h want 0:ddccbbaa", wr_addr[0], wr_data[0]); end
    end
    n_cmp++; if (load_done !== 1'b0 || cpu_rst !== 1'b1) begin n_bad++; $display("FAIL mid_after_rst: got done=%b cpu_rst=%b want 0/1", load_done, cpu_rst); end
    wr_addr.delete(); wr_data.delete();
    @(posedge clk); #1;
    frm = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send(1'b0);
    @(negedge clk);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL mid_new_done: got %b want 1", load_done); end
    n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL mid_new_err: got %0d want 0", err_code); end
    n_cmp++; if (wr_addr.size() != 1) begin n_bad++; $display("FAIL mid_new_nwrites: got %0d want 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      n_cmp++; if (wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h12345678) begin n_bad++; $display("FAIL mid_new_w0: got %0d:%h want 0:12345678", wr_addr[0], wr_data[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame(1'b0, "basic");
    test_good_frame(1'b1, "gaps");
    test_len_overflow();
    test_csum_error();
    test_empty_frame();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
